// File: rtl/uart_mmio_pkg.sv
// Shared constants for the memory-mapped UART block: register offsets,
// STATUS/CTRL bit positions and the TX drain FSM state type.
package uart_mmio_pkg;

  localparam logic [1:0] OFF_STATUS = 2'd0;
  localparam logic [1:0] OFF_TXDATA = 2'd1;
  localparam logic [1:0] OFF_RXDATA = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  localparam int ST_RX_NOT_EMPTY = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_TX_IDLE      = 2;
  localparam int ST_RX_OVERRUN   = 3;
  localparam int ST_TX_OVERFLOW  = 4;
  localparam int ST_RX_COUNT_LSB = 8;
  localparam int ST_TX_COUNT_LSB = 16;

  localparam int CTRL_CLR_STICKY = 0;
  localparam int CTRL_FLUSH      = 1;
  localparam int CTRL_IRQ_EN_RX  = 2;
  localparam int CTRL_IRQ_EN_TX  = 3;

  // Cycles spent waiting for uartTx to report busy before assuming a
  // short busy pulse was missed by the synchroniser.
  localparam int TX_WAIT_LIMIT = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_WAIT_BUSY,
    TX_WAIT_DONE
  } tx_state_e;

  // Occupancy counts are reported in 8-bit STATUS fields; a 256-deep FIFO
  // that is full reads back as 8'hff instead of wrapping to 0.
  function automatic logic [7:0] sat_byte(input logic [15:0] v);
    return (v > 16'd255) ? 8'hff : v[7:0];
  endfunction

endpackage

// File: rtl/uart_mmio_fifo_sync_fifo.sv
// Single-clock FIFO with flush, used for both UART directions.
// Push when full and pop when empty are ignored; flush wins over both.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     RST,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone defines what is valid.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART register window with TX/RX FIFOs.
// Optional feature macro: UART_MMIO_IRQ_EN (interrupt enables in CTRL and
// a registered irq output); without it irq is tied low.
//
// TX drain FSM:
//   state        | meaning
//   TX_IDLE      | nothing in flight; leave when the TX FIFO has a byte
//   TX_LOAD      | uartWE pulse with the head byte, pop it
//   TX_WAIT_BUSY | wait for synced busy, give up after TX_WAIT_LIMIT cycles
//   TX_WAIT_DONE | wait for synced busy to drop, then back to idle
module uart_mmio_fifo
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h200,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        RST,
  input  logic [31:0] vaddr,
  input  logic [31:0] data,
  input  logic        memWE,
  input  logic        memRE,
  output logic        hit,
  output logic [31:0] q,
  output logic [7:0]  uartTxIn,
  output logic        uartWE,
  input  logic        uartTxBusy,
  input  logic [7:0]  uartRxOut,
  input  logic        uartRxFin,
  output logic        irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]      win_off;
  logic             in_win;
  logic [1:0]       off;
  logic             wr_acc;
  logic             rd_acc;
  logic             tx_push;
  logic             rx_pop;
  logic             ctrl_wr;
  logic             flush;
  logic             clr_sticky;

  logic             busy_s1, busy_s2;
  logic             fin_s1, fin_s2, fin_s3;
  logic             rx_edge;

  logic [7:0]       tx_head, rx_head;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic [CNT_W-1:0] tx_count, rx_count;
  logic             tx_pop;

  logic             rx_overrun, tx_overflow;
  tx_state_e        state, state_next;
  logic [2:0]       wait_cnt;
  logic             uart_we;
  logic [7:0]       tx_byte;
  logic             tx_idle;
  logic [31:0]      status;
  logic [31:0]      ctrl_rd;
  logic [31:0]      rd_data;
  logic             unused_data;

  assign win_off    = vaddr - BASE_ADDR;
  assign in_win     = (win_off < 32'd4);
  assign off        = win_off[1:0];
  assign wr_acc     = memWE & in_win;
  // A simultaneous write suppresses the read side, including the RX pop.
  assign rd_acc     = memRE & in_win & ~memWE;
  assign tx_push    = wr_acc & (off == OFF_TXDATA);
  assign rx_pop     = rd_acc & (off == OFF_RXDATA);
  assign ctrl_wr    = wr_acc & (off == OFF_CTRL);
  assign flush      = ctrl_wr & data[CTRL_FLUSH];
  assign clr_sticky = ctrl_wr & data[CTRL_CLR_STICKY];
  assign rx_edge    = fin_s2 & ~fin_s3;

  // Two-flop synchronisers for the uart core signals, plus one extra fin
  // stage for rising-edge detection.
  always_ff @(posedge clock or negedge RST) begin
    if (!RST) begin
      busy_s1 <= 1'b0;
      busy_s2 <= 1'b0;
      fin_s1  <= 1'b0;
      fin_s2  <= 1'b0;
      fin_s3  <= 1'b0;
    end else begin
      busy_s1 <= uartTxBusy;
      busy_s2 <= busy_s1;
      fin_s1  <= uartRxFin;
      fin_s2  <= fin_s1;
      fin_s3  <= fin_s2;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock     (clock),
    .RST       (RST),
    .push      (tx_push),
    .push_data (data[7:0]),
    .pop       (tx_pop),
    .flush     (flush),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  // uartRxOut is held stable while fin is high, so it is safe to take it
  // directly when the synchronised edge arrives.
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock     (clock),
    .RST       (RST),
    .push      (rx_edge),
    .push_data (uartRxOut),
    .pop       (rx_pop),
    .flush     (flush),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  // Sticky error flags; a new event in the clearing cycle is kept.
  always_ff @(posedge clock or negedge RST) begin
    if (!RST) begin
      rx_overrun  <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      rx_overrun  <= (rx_overrun  & ~clr_sticky) | (rx_edge & rx_full);
      tx_overflow <= (tx_overflow & ~clr_sticky) | (tx_push & tx_full);
    end
  end

  // TX FSM state register and wait-for-busy down-counter.
  always_ff @(posedge clock or negedge RST) begin
    if (!RST) begin
      state    <= TX_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == TX_LOAD) begin
        wait_cnt <= 3'(TX_WAIT_LIMIT - 1);
      end else if (state == TX_WAIT_BUSY && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
    end
  end

  // TX FSM next state and load/pop strobes; flush forces idle silently.
  always_comb begin
    state_next = state;
    uart_we    = 1'b0;
    tx_pop     = 1'b0;
    case (state)
      TX_IDLE:      if (!tx_empty) state_next = TX_LOAD;
      TX_LOAD: begin
        uart_we    = 1'b1;
        tx_pop     = 1'b1;
        state_next = TX_WAIT_BUSY;
      end
      TX_WAIT_BUSY: if (busy_s2 || wait_cnt == '0) state_next = TX_WAIT_DONE;
      TX_WAIT_DONE: if (!busy_s2) state_next = TX_IDLE;
      default:      state_next = TX_IDLE;
    endcase
    if (flush) begin
      state_next = TX_IDLE;
      uart_we    = 1'b0;
      tx_pop     = 1'b0;
    end
  end

  // Capture the head byte on the way into LOAD so uartTxIn is already
  // stable while uartWE is high, and holds afterwards.
  always_ff @(posedge clock or negedge RST) begin
    if (!RST) begin
      tx_byte <= 8'hff;
    end else if (state == TX_IDLE && !tx_empty && !flush) begin
      tx_byte <= tx_head;
    end
  end

  assign uartWE   = uart_we;
  assign uartTxIn = tx_byte;
  assign tx_idle  = tx_empty & (state == TX_IDLE);

  // STATUS word assembled from live FIFO and sticky state.
  always_comb begin
    status = '0;
    status[ST_RX_NOT_EMPTY] = ~rx_empty;
    status[ST_TX_FULL]      = tx_full;
    status[ST_TX_IDLE]      = tx_idle;
    status[ST_RX_OVERRUN]   = rx_overrun;
    status[ST_TX_OVERFLOW]  = tx_overflow;
    status[ST_RX_COUNT_LSB +: 8] = sat_byte(16'(rx_count));
    status[ST_TX_COUNT_LSB +: 8] = sat_byte(16'(tx_count));
  end

`ifdef UART_MMIO_IRQ_EN
  logic irq_en_rx, irq_en_tx, irq_q;

  // Interrupt enables live in CTRL; irq is a registered OR of the sources.
  always_ff @(posedge clock or negedge RST) begin
    if (!RST) begin
      irq_en_rx <= 1'b0;
      irq_en_tx <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        irq_en_rx <= data[CTRL_IRQ_EN_RX];
        irq_en_tx <= data[CTRL_IRQ_EN_TX];
      end
      irq_q <= (irq_en_rx & (~rx_empty | rx_overrun)) | (irq_en_tx & tx_idle);
    end
  end

  assign irq         = irq_q;
  assign ctrl_rd     = {30'h0, irq_en_tx, irq_en_rx};
  assign unused_data = ^data[31:8];
`else
  assign irq         = 1'b0;
  assign ctrl_rd     = '0;
  assign unused_data = ^{data[31:8], data[CTRL_IRQ_EN_TX:CTRL_IRQ_EN_RX]};
`endif

  // Read mux; an empty RX FIFO reads as 0.
  always_comb begin
    rd_data = '0;
    case (off)
      OFF_STATUS: rd_data = status;
      OFF_RXDATA: rd_data = rx_empty ? 32'h0 : {24'h0, rx_head};
      OFF_CTRL:   rd_data = ctrl_rd;
      default:    rd_data = '0;
    endcase
  end

  // Registered read data and hit flag; q only changes on a read strobe.
  always_ff @(posedge clock or negedge RST) begin
    if (!RST) begin
      q   <= '0;
      hit <= 1'b0;
    end else begin
      hit <= (memWE | memRE) & in_win;
      if (memRE) q <= rd_acc ? rd_data : 32'h0;
    end
  end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Self-checking bench for uart_mmio_fifo: bus accesses push expected
// responses into a queue that a monitor checks; TX loads are checked
// against a queue of expected bytes. Honours UART_MMIO_IRQ_EN.
module tb_uart_mmio_fifo;

  localparam logic [31:0] BASE  = 32'h200;
  localparam int          DEPTH = 8;
`ifdef UART_MMIO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] vaddr = '0;
  logic [31:0] data = '0;
  logic        memWE = 1'b0;
  logic        memRE = 1'b0;
  logic        hit;
  logic [31:0] q;
  logic [7:0]  uartTxIn;
  logic        uartWE;
  logic        uartTxBusy = 1'b0;
  logic [7:0]  uartRxOut = '0;
  logic        uartRxFin = 1'b0;
  logic        irq;

  always #5 clock = ~clock;

  uart_mmio_fifo dut (
    .clock      (clock),
    .RST        (RST),
    .vaddr      (vaddr),
    .data       (data),
    .memWE      (memWE),
    .memRE      (memRE),
    .hit        (hit),
    .q          (q),
    .uartTxIn   (uartTxIn),
    .uartWE     (uartWE),
    .uartTxBusy (uartTxBusy),
    .uartRxOut  (uartRxOut),
    .uartRxFin  (uartRxFin),
    .irq        (irq)
  );

  typedef struct {
    logic        rd;
    logic        hit;
    logic [31:0] q;
  } acc_t;

  int          n_checks = 0;
  int          n_fail = 0;
  acc_t        acc_q[$];
  logic [7:0]  tx_exp[$];
  logic [7:0]  rx_q[$];
  bit          rx_ovr = 0;
  bit          tx_ovf = 0;
  bit          en_rx = 0;
  bit          en_tx = 0;
  logic [31:0] last_q = '0;
  int          busy_mode = 1;   // 0: never busy, 1: 10-cycle busy per byte, 2: held high
  int          busy_cnt = 0;
  logic        acc_seen;
  acc_t        mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus access monitor: hit/q checked the cycle after each strobe, q hold otherwise.
  always @(posedge clock or negedge RST)
    if (!RST) acc_seen <= 1'b0;
    else      acc_seen <= memWE | memRE;

  always @(negedge clock) begin
    if (RST) begin
      if (acc_seen) begin
        if (acc_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL acc_unexpected: hit %b q %h with no access pending", hit, q);
        end else begin
          mon_e = acc_q.pop_front();
          chk("hit", 32'(hit), 32'(mon_e.hit));
          if (mon_e.rd) begin
            chk("rdata", q, mon_e.q);
            last_q = mon_e.q;
          end else begin
            chk("q_hold", q, last_q);
          end
        end
      end else begin
        chk("hit_idle", 32'(hit), 32'h0);
        chk("q_hold", q, last_q);
      end
    end
  end

  // TX monitor plus uartTx busy model.
  always @(negedge clock) begin
    if (RST && uartWE) begin
      chk("tx_we_while_busy", busy_cnt, 0);
      if (tx_exp.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL tx_unexpected_load: uartTxIn %h with no byte expected", uartTxIn);
      end else begin
        chk("tx_byte", 32'(uartTxIn), 32'(tx_exp.pop_front()));
      end
      if (busy_mode == 1) busy_cnt = 10;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    uartTxBusy = (busy_mode == 2) || (busy_cnt > 0);
  end

  task automatic bus(input logic [31:0] addr, input logic we, input logic re,
                     input logic [31:0] wd, input logic [31:0] exp_q);
    acc_t e;
    @(negedge clock);
    vaddr = addr; data = wd; memWE = we; memRE = re;
    e.rd  = re;
    e.hit = ((addr - BASE) < 32'd4);
    e.q   = (re && !we) ? exp_q : 32'h0;
    acc_q.push_back(e);
    @(negedge clock);
    memWE = 1'b0; memRE = 1'b0; vaddr = '0; data = '0;
  endtask

  task automatic tx_write(input logic [7:0] b);
    if (tx_exp.size() < DEPTH) tx_exp.push_back(b);
    else tx_ovf = 1;
    bus(BASE + 32'd1, 1'b1, 1'b0, {24'h0, b}, 32'h0);
  endtask

  task automatic ctrl_write(input logic [31:0] v);
    if (v[0]) begin rx_ovr = 0; tx_ovf = 0; end
    if (v[1]) begin tx_exp.delete(); rx_q.delete(); end
    if (IRQ_ON) begin en_rx = v[2]; en_tx = v[3]; end
    bus(BASE + 32'd3, 1'b1, 1'b0, v, 32'h0);
  endtask

  task automatic rd_rx();
    logic [31:0] e;
    e = (rx_q.size() != 0) ? {24'h0, rx_q.pop_front()} : 32'h0;
    bus(BASE + 32'd2, 1'b0, 1'b1, 32'h0, e);
  endtask

  task automatic rd_ctrl();
    bus(BASE + 32'd3, 1'b0, 1'b1, 32'h0, {30'h0, en_tx, en_rx});
  endtask

  // Expected STATUS from the model; fsm_idle says whether a byte is still in flight.
  task automatic rd_status(input bit fsm_idle);
    logic [31:0] e;
    e = '0;
    e[0] = (rx_q.size() != 0);
    e[1] = (tx_exp.size() == DEPTH);
    e[2] = fsm_idle && (tx_exp.size() == 0);
    e[3] = rx_ovr;
    e[4] = tx_ovf;
    e[15:8]  = 8'(rx_q.size());
    e[23:16] = 8'(tx_exp.size());
    bus(BASE, 1'b0, 1'b1, 32'h0, e);
  endtask

  task automatic rx_send(input logic [7:0] b);
    @(negedge clock);
    uartRxOut = b; uartRxFin = 1'b1;
    repeat (3) @(negedge clock);
    uartRxFin = 1'b0;
    repeat (3) @(negedge clock);
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
    else rx_ovr = 1;
  endtask

  task automatic drain_tx();
    int cyc = 0;
    while ((tx_exp.size() != 0 || busy_cnt != 0) && cyc < 3000) begin
      @(negedge clock);
      cyc++;
    end
    if (cyc >= 3000) begin
      n_checks++; n_fail++;
      $display("FAIL tx_drain_timeout: %0d bytes still expected", tx_exp.size());
    end
    repeat (16) @(negedge clock);
  endtask

  initial begin
    int cyc;
    int n;
    logic [31:0] a;

    // Reset values
    repeat (3) @(negedge clock);
    chk("rst_q", q, 32'h0);
    chk("rst_hit", 32'(hit), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_uartWE", 32'(uartWE), 32'h0);
    chk("rst_uartTxIn", 32'(uartTxIn), 32'hff);
    RST = 1'b1;
    repeat (2) @(negedge clock);

    rd_status(1);
    rd_ctrl();
    bus(BASE + 32'd1, 1'b0, 1'b1, 32'h0, 32'h0);

    // Outside the window: no hit, no side effects
    bus(32'h100, 1'b0, 1'b1, 32'h0, 32'h0);
    bus(BASE + 32'd4, 1'b1, 1'b0, 32'h41, 32'h0);
    bus(BASE - 32'd1, 1'b1, 1'b0, 32'h42, 32'h0);
    repeat (10) @(negedge clock);
    rd_status(1);

    // Two bytes with a 10-cycle busy
    busy_mode = 1;
    tx_write(8'h41);
    tx_write(8'h42);
    drain_tx();
    rd_status(1);

    // Overflow with busy held high: one byte in flight, 8 queued, 1 dropped
    busy_mode = 2;
    for (int i = 0; i < 10; i++) tx_write(8'(8'h60 + i));
    repeat (20) @(negedge clock);
    rd_status(0);
    ctrl_write(32'h1);
    rd_status(0);
    ctrl_write(32'h2);
    busy_mode = 1;
    repeat (10) @(negedge clock);
    rd_status(1);

    // Single RX byte
    rx_send(8'h5A);
    rd_status(1);
    rd_rx();
    rd_rx();
    rd_status(1);

    // RX overrun
    for (int i = 0; i < 9; i++) rx_send(8'(8'h80 + i));
    rd_status(1);
    ctrl_write(32'h1);
    rd_status(1);
    ctrl_write(32'h2);
    rd_status(1);

    // Write and read together: write lands, read returns 0
    bus(BASE + 32'd1, 1'b1, 1'b1, 32'h77, 32'h0);
    tx_exp.push_back(8'h77);
    drain_tx();

    // busy never seen: FSM times out of WAIT_BUSY
    busy_mode = 0;
    tx_write(8'hA1);
    tx_write(8'hA2);
    tx_write(8'hA3);
    drain_tx();
    rd_status(1);
    busy_mode = 1;

    // Randomised mix
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 5))
        0: begin
          busy_mode = int'($urandom_range(0, 1));
          n = int'($urandom_range(1, 5));
          for (int k = 0; k < n; k++) tx_write(8'($urandom));
          drain_tx();
        end
        1: rx_send(8'($urandom));
        2: rd_rx();
        3: begin drain_tx(); rd_status(1); end
        4: begin
          a = ($urandom_range(0, 1) != 0) ? BASE : BASE + 32'd2;
          bus(a, 1'b1, 1'b0, $urandom, 32'h0);
        end
        default: begin
          a = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 32'h1ff))
                                           : BASE + 32'd4 + 32'($urandom_range(0, 1000));
          if ($urandom_range(0, 1) != 0) bus(a, 1'b0, 1'b1, 32'h0, 32'h0);
          else bus(a, 1'b1, 1'b0, $urandom, 32'h0);
        end
      endcase
    end
    busy_mode = 1;
    drain_tx();
    rd_status(1);

    // Interrupts (stay low when the feature is compiled out)
    ctrl_write(32'h3);
    ctrl_write(32'h4);
    repeat (3) @(negedge clock);
    chk("irq_rx_empty", 32'(irq), 32'h0);
    rd_ctrl();
    rx_send(8'h11);
    repeat (2) @(negedge clock);
    chk("irq_rx_byte", 32'(irq), 32'(IRQ_ON));
    rd_rx();
    repeat (3) @(negedge clock);
    chk("irq_rx_popped", 32'(irq), 32'h0);
    ctrl_write(32'h8);
    repeat (3) @(negedge clock);
    chk("irq_tx_empty", 32'(irq), 32'(IRQ_ON));
    ctrl_write(32'h0);
    repeat (3) @(negedge clock);
    chk("irq_disabled", 32'(irq), 32'h0);

    // Reset mid-TX: outputs return to reset values immediately
    tx_write(8'hC3);
    cyc = 0;
    while (tx_exp.size() != 0 && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    chk("tx_loaded_before_reset", 32'(cyc < 200), 32'h1);
    repeat (2) @(negedge clock);
    #2 RST = 1'b0;
    #1;
    chk("midrst_q", q, 32'h0);
    chk("midrst_hit", 32'(hit), 32'h0);
    chk("midrst_uartWE", 32'(uartWE), 32'h0);
    chk("midrst_uartTxIn", 32'(uartTxIn), 32'hff);
    chk("midrst_irq", 32'(irq), 32'h0);
    tx_exp.delete(); rx_q.delete(); acc_q.delete();
    rx_ovr = 0; tx_ovf = 0; en_rx = 0; en_tx = 0; last_q = '0;
    repeat (3) @(negedge clock);
    RST = 1'b1;
    repeat (20) @(negedge clock);
    rd_status(1);
    repeat (3) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
